// File: rtl/pal_cfg_loader.sv
// Byte-wide PAL bitstream loader: serializes bytes LSB-first onto cfg_data/cfg_clk,
// checks a trailing CRC-8 byte and enables the PAL only after a clean load.
module pal_cfg_loader #(
    parameter int BITSTREAM_LEN = 231,
    parameter int HALF_PERIOD   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_data,
    output logic       cfg_clk,
    output logic       pal_enable,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic [2:0] dbg_state
);
    localparam int CW  = $clog2(BITSTREAM_LEN + 1);
    localparam int HPW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0]  LEN_C   = CW'(BITSTREAM_LEN);
    localparam logic [HPW-1:0] HP_LAST = HPW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SHIFT     = 3'd2,
        WAIT_CRC  = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t         state_q;
    logic [7:0]     byte_q;
    logic [7:0]     rx_crc_q;
    logic [7:0]     crc_q, crc_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [HPW-1:0] hp_cnt_q, hp_cnt_d;
    logic [2:0]     bit_idx_q;
    logic           phase_q;
    logic           in_ready_q, cfg_data_q, cfg_clk_q;
    logic           pal_enable_q, busy_q, done_q, crc_err_q;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    always_comb begin
        crc_d     = crc_step(crc_q, cfg_data_q);
        bit_cnt_d = bit_cnt_q + CW'(1);
        hp_cnt_d  = hp_cnt_q + HPW'(1);
    end

    // A byte transfers on any rising clk edge where in_valid and in_ready are both 1;
    // in_ready is registered and only high in WAIT_BYTE / WAIT_CRC, and start wins over it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            rx_crc_q     <= 8'h00;
            crc_q        <= 8'h00;
            bit_cnt_q    <= '0;
            hp_cnt_q     <= '0;
            bit_idx_q    <= 3'd0;
            phase_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            cfg_data_q   <= 1'b0;
            cfg_clk_q    <= 1'b0;
            pal_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
        end else if (start) begin
            state_q      <= WAIT_BYTE;
            crc_q        <= 8'h00;
            bit_cnt_q    <= '0;
            hp_cnt_q     <= '0;
            bit_idx_q    <= 3'd0;
            phase_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            cfg_data_q   <= 1'b0;
            cfg_clk_q    <= 1'b0;
            pal_enable_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            case (state_q)
                WAIT_BYTE: begin
                    if (in_valid && in_ready_q) begin
                        byte_q     <= in_data;
                        cfg_data_q <= in_data[0];
                        in_ready_q <= 1'b0;
                        hp_cnt_q   <= '0;
                        phase_q    <= 1'b0;
                        bit_idx_q  <= 3'd0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hp_cnt_q != HP_LAST) begin
                        hp_cnt_q <= hp_cnt_d;
                    end else begin
                        hp_cnt_q <= '0;
                        if (!phase_q) begin
                            // Rising cfg_clk: the bit is committed to the chain and the CRC.
                            phase_q   <= 1'b1;
                            cfg_clk_q <= 1'b1;
                            crc_q     <= crc_d;
                            bit_cnt_q <= bit_cnt_d;
                        end else begin
                            phase_q   <= 1'b0;
                            cfg_clk_q <= 1'b0;
                            if (bit_cnt_q == LEN_C) begin
                                state_q    <= WAIT_CRC;
                                in_ready_q <= 1'b1;
                            end else if (bit_idx_q == 3'd7) begin
                                state_q    <= WAIT_BYTE;
                                in_ready_q <= 1'b1;
                            end else begin
                                bit_idx_q  <= bit_idx_q + 3'd1;
                                byte_q     <= {1'b0, byte_q[7:1]};
                                cfg_data_q <= byte_q[1];
                            end
                        end
                    end
                end
                WAIT_CRC: begin
                    if (in_valid && in_ready_q) begin
                        rx_crc_q   <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    if (rx_crc_q == crc_q) begin
                        state_q      <= DONE;
                        pal_enable_q <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        state_q   <= ERROR;
                        crc_err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign cfg_data   = cfg_data_q;
    assign cfg_clk    = cfg_clk_q;
    assign pal_enable = pal_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign crc_err    = crc_err_q;
    assign dbg_state  = state_q;
endmodule
